mux_rr_pipe: RTL

Parametrised, registered N-channel data selector. It succeeds the combinational 4:1 5-bit mux used in the datapath. Each input channel has a valid/ready handshake. Selection is either fixed (external select) or round-robin across valid channels. The output is registered with one cycle of latency and holds under backpressure, which makes the block suitable for sharing a register-file write port or result bus between several producers.

---
 rtl/mux_rr_pipe_if.sv | 24 ++
 rtl/mux_rr_pipe.sv | 85 ++++++++
 2 files changed

// File: rtl/mux_rr_pipe_if.sv
// rtl/mux_rr_pipe_if.sv - channel and output handshake bundle for mux_rr_pipe
interface mux_rr_pipe_if #(
  parameter int WIDTH = 5,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_chan;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_rr_pipe.sv
// rtl/mux_rr_pipe.sv - registered N-channel selector, fixed or round-robin grant
// Optional transfer counter enabled by defining MUX_XFER_CNT_EN.
module mux_rr_pipe #(
  parameter int WIDTH = 5,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] select,
  mux_rr_pipe_if.slave     bus,
  output logic [15:0]      xfer_cnt
);
  localparam logic [SEL_W:0] NCH_W = (SEL_W+1)'(NCH);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt;
  logic             gnt_valid;
  logic             space;
  logic             load;
  logic [SEL_W:0]   rr_idx;

  // Scan from the farthest candidate back toward ptr so the nearest valid one wins.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    rr_idx    = '0;
    if (!mode) begin
      if ({1'b0, select} < NCH_W) begin
        gnt_valid = bus.in_valid[select];
        gnt       = select;
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        rr_idx = {1'b0, ptr} + (SEL_W+1)'(k);
        if (rr_idx >= NCH_W) rr_idx = rr_idx - NCH_W;
        if (bus.in_valid[rr_idx[SEL_W-1:0]]) begin
          gnt_valid = 1'b1;
          gnt       = rr_idx[SEL_W-1:0];
        end
      end
    end
  end

  assign space = ~bus.out_valid | bus.out_ready;
  assign load  = gnt_valid & space;

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.in_ready[i] = load & (gnt == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_chan  <= '0;
      ptr           <= '0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[int'(gnt)*WIDTH +: WIDTH];
      bus.out_chan  <= gnt;
      if (mode) begin
        ptr <= ({1'b0, gnt} == NCH_W - 1'b1) ? '0 : gnt + 1'b1;
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef MUX_XFER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`else
  assign xfer_cnt = 16'h0000;
`endif
endmodule
